fft_band_peak_detector: RTL

- Sits directly downstream of FFTcore and consumes its Avalon-ST source stream: valid, sop, eop, real, imag and block exponent.
- Computes an approximate magnitude for each positive-frequency bin and normalises it by the block exponent.
- Reduces each frame to NUM_BANDS linear bands by peak-hold, then emits one band value per band, in order, to the display/bar logic.
- No backpressure: FFTcore source_ready is tied high, so every input beat must be accepted.

---
 rtl/fft_band_peak_detector_if.sv | 37 +++
 rtl/fft_band_peak_detector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_band_peak_detector_if.sv
// Stream bundle between FFTcore's Avalon-ST source and the band peak detector,
// together with the band result strobes that go on to the display/bar logic.
//   src_valid/sop/eop : beat qualifiers (no backpressure, ready is tied high)
//   src_real/src_imag : signed 24-bit bin value
//   src_exp           : signed block exponent, travels with each beat
//   band_valid        : one-cycle strobe, band_idx/band_mag valid
//   frame_done        : strobes together with the last band of a frame
//   frame_err         : strobes on a framing violation
// master = stream producer / result consumer, slave = detector.
interface fft_band_peak_detector_if #(
  parameter int NUM_BANDS = 16,
  parameter int OUT_W     = 33
);
  localparam int IDX_W = $clog2(NUM_BANDS);

  logic                    src_valid;
  logic                    src_sop;
  logic                    src_eop;
  logic signed [23:0]      src_real;
  logic signed [23:0]      src_imag;
  logic signed [5:0]       src_exp;
  logic                    band_valid;
  logic [IDX_W-1:0]        band_idx;
  logic [OUT_W-1:0]        band_mag;
  logic                    frame_done;
  logic                    frame_err;

  modport master (
    output src_valid, src_sop, src_eop, src_real, src_imag, src_exp,
    input  band_valid, band_idx, band_mag, frame_done, frame_err
  );

  modport slave (
    input  src_valid, src_sop, src_eop, src_real, src_imag, src_exp,
    output band_valid, band_idx, band_mag, frame_done, frame_err
  );
endinterface

// File: rtl/fft_band_peak_detector.sv
// Reduces each FFT frame to NUM_BANDS peak-hold band magnitudes.
// Ports:
//   MCLK  : system clock, all logic on posedge
//   reset : asynchronous active-low reset
//   bus   : slave side of fft_band_peak_detector_if (stream in, bands out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a beat with sop
// BINS  | feeding positive-frequency bins 0..FFT_N/2-1 into the pipe
// SKIP  | discarding negative-frequency bins until eop
module fft_band_peak_detector #(
  parameter int FFT_N     = 1024,
  parameter int NUM_BANDS = 16,
  parameter int MAX_SHIFT = 8,
  parameter int OUT_W     = 25 + MAX_SHIFT
) (
  input logic                    MCLK,
  input logic                    reset,
  fft_band_peak_detector_if.slave bus
);
  localparam int HALF  = FFT_N / 2;
  localparam int BIN_W = $clog2(HALF);
  localparam int BPB   = HALF / NUM_BANDS;
  localparam int BPB_W = $clog2(BPB);
  localparam int IDX_W = $clog2(NUM_BANDS);
  localparam int SH_W  = $clog2(MAX_SHIFT + 1);
  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_BAND = IDX_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {IDLE, BINS, SKIP} state_t;

  function automatic logic [23:0] abs_sat(input logic [23:0] v);
    if (v == 24'h80_0000)  abs_sat = 24'h7f_ffff;
    else if (v[23])        abs_sat = ~v + 24'd1;
    else                   abs_sat = v;
  endfunction

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               take, err;
  logic [BIN_W-1:0]   take_bin;

  logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic [BIN_W-1:0]   s1_bin_q, s1_bin_d, s2_bin_q, s2_bin_d, s3_bin_q, s3_bin_d;
  logic [23:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [5:0]         s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
  logic [24:0]        s2_mag_q, s2_mag_d;
  logic [OUT_W-1:0]   s3_mag_q, s3_mag_d;
  logic [OUT_W-1:0]   peak_q, peak_d, peak_new;

  logic               band_valid_q, band_valid_d, frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [IDX_W-1:0]   band_idx_q, band_idx_d;
  logic [OUT_W-1:0]   band_mag_q, band_mag_d;

  logic [23:0]        mx, mn;
  logic [5:0]         exp_neg;
  logic [SH_W-1:0]    sh;
  logic [BPB_W-1:0]   s3_off;
  logic [IDX_W-1:0]   s3_band;

  // Framing control: decides whether the current beat enters the pipe and as which bin.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    take     = 1'b0;
    take_bin = bin_q;
    err      = 1'b0;
    if (bus.src_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.src_sop) begin
            take     = 1'b1;
            take_bin = '0;
            bin_d    = BIN_W'(1);
            state_d  = BINS;
          end
        end
        BINS: begin
          if (bus.src_sop) begin
            err      = 1'b1;
            take     = 1'b1;
            take_bin = '0;
            bin_d    = BIN_W'(1);
          end else if (bus.src_eop) begin
            err     = 1'b1;
            bin_d   = '0;
            state_d = IDLE;
          end else begin
            take  = 1'b1;
            bin_d = bin_q + BIN_W'(1);
            if (bin_q == LAST_BIN) begin
              bin_d   = '0;
              state_d = SKIP;
            end
          end
        end
        SKIP: begin
          if (bus.src_sop) begin
            err      = 1'b1;
            take     = 1'b1;
            take_bin = '0;
            bin_d    = BIN_W'(1);
            state_d  = BINS;
          end else if (bus.src_eop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Magnitude pipeline. A framing error flushes S2/S3 and blocks the S4 update,
  // so the interrupted band never reaches the output.
  always_comb begin
    s1_valid_d = take;
    s1_bin_d   = take_bin;
    s1_exp_d   = bus.src_exp;
    s1_a_d     = (take_bin == '0) ? 24'd0 : abs_sat(bus.src_real);
    s1_b_d     = (take_bin == '0) ? 24'd0 : abs_sat(bus.src_imag);

    mx         = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
    mn         = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
    s2_valid_d = s1_valid_q & ~err;
    s2_bin_d   = s1_bin_q;
    s2_exp_d   = s1_exp_q;
    s2_mag_d   = {1'b0, mx} + {3'b000, mn[23:2]};

    // Negative exponent means the core scaled down; undo it, capped at MAX_SHIFT.
    exp_neg = 6'd0 - s2_exp_q;
    if (!s2_exp_q[5])                   sh = '0;
    else if (exp_neg > 6'(MAX_SHIFT))   sh = SH_W'(MAX_SHIFT);
    else                                sh = exp_neg[SH_W-1:0];
    s3_valid_d = s2_valid_q & ~err;
    s3_bin_d   = s2_bin_q;
    s3_mag_d   = {{(OUT_W-25){1'b0}}, s2_mag_q} << sh;

    s3_off   = s3_bin_q[BPB_W-1:0];
    s3_band  = s3_bin_q[BIN_W-1:BPB_W];
    peak_new = (s3_off == '0) ? s3_mag_q : ((s3_mag_q > peak_q) ? s3_mag_q : peak_q);

    peak_d       = peak_q;
    band_valid_d = 1'b0;
    frame_done_d = 1'b0;
    band_idx_d   = band_idx_q;
    band_mag_d   = band_mag_q;
    frame_err_d  = err;
    if (s3_valid_q && !err) begin
      peak_d = peak_new;
      if (s3_off == {BPB_W{1'b1}}) begin
        band_valid_d = 1'b1;
        band_idx_d   = s3_band;
        band_mag_d   = peak_new;
        frame_done_d = (s3_band == LAST_BAND);
      end
    end
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_exp_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_bin_q     <= '0;
      s2_exp_q     <= '0;
      s2_mag_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_bin_q     <= '0;
      s3_mag_q     <= '0;
      peak_q       <= '0;
      band_valid_q <= 1'b0;
      band_idx_q   <= '0;
      band_mag_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      s1_valid_q   <= s1_valid_d;
      s1_bin_q     <= s1_bin_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_exp_q     <= s1_exp_d;
      s2_valid_q   <= s2_valid_d;
      s2_bin_q     <= s2_bin_d;
      s2_exp_q     <= s2_exp_d;
      s2_mag_q     <= s2_mag_d;
      s3_valid_q   <= s3_valid_d;
      s3_bin_q     <= s3_bin_d;
      s3_mag_q     <= s3_mag_d;
      peak_q       <= peak_d;
      band_valid_q <= band_valid_d;
      band_idx_q   <= band_idx_d;
      band_mag_q   <= band_mag_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.band_valid = band_valid_q;
  assign bus.band_idx   = band_idx_q;
  assign bus.band_mag   = band_mag_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
endmodule
